// File: rtl/xbar_sched_if.sv
// Crossbar scheduler bus bundle.
//   req   [16] req[i*4+j]  : input i head flit is destined for output j
//   tail  [4]  tail[i]     : head flit of input i ends its packet
//   ordy  [4]  ordy[j]     : output j can accept a flit this cycle
//   grant [16] grant[j*4+i]: output j is locked to input i
//   ack   [4]  ack[i]      : head flit of input i moves this cycle
//   ovld  [4]  ovld[j]     : a flit moves to output j this cycle
//   err   [4]  err[j]      : sticky, output j had a timeout release
// master drives requests and observes the schedule; slave is the scheduler.
interface xbar_sched_if;
  logic [15:0] req;
  logic [3:0]  tail;
  logic [3:0]  ordy;
  logic [15:0] grant;
  logic [3:0]  ack;
  logic [3:0]  ovld;
  logic [3:0]  err;

  modport master (
    output req, tail, ordy,
    input  grant, ack, ovld, err
  );

  modport slave (
    input  req, tail, ordy,
    output grant, ack, ovld, err
  );
endinterface

// File: rtl/xbar_sched.sv
// 4x4 crossbar output scheduler with packet-granular locking.
// Each output arbitrates round-robin among requesting inputs while idle,
// then stays locked to the winner until the tail flit transfers or the
// output stalls TMO consecutive locked cycles (forced release, sticky err).
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-low reset
//   bus : xbar_sched_if slave modport (req/tail/ordy in, grant/ack/ovld/err out)
// Parameter:
//   TMO : stalled locked cycles before forced release (2..255)
module xbar_sched #(
  parameter int unsigned TMO = 16
) (
  input  logic        clk,
  input  logic        rst,
  xbar_sched_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [0:0] state_q [4];
  logic [0:0] state_d [4];
  logic [1:0] owner_q [4];
  logic [1:0] owner_d [4];
  logic [1:0] ptr_q   [4];
  logic [1:0] ptr_d   [4];
  logic [7:0] cnt_q   [4];
  logic [7:0] cnt_d   [4];
  logic [3:0] err_q;
  logic [3:0] err_d;

  // Per-output views: req_by_out[j][i] = request of input i for output j,
  // own_by_out[j][i] = output j is locked to input i.
  logic [3:0][3:0] req_by_out;
  logic [3:0][3:0] own_by_out;
  logic [3:0]      xfer;
  logic [3:0]      busy;
  logic [3:0]      ack_v;
  logic [3:0]      picked;

  for (genvar j = 0; j < 4; j++) begin : g_out
    for (genvar i = 0; i < 4; i++) begin : g_in
      assign req_by_out[j][i] = bus.req[i*4+j];
      assign own_by_out[j][i] = (state_q[j] == LOCK) && (owner_q[j] == 2'(i));
      assign bus.grant[j*4+i] = own_by_out[j][i];
    end
  end

  always_comb begin
    xfer  = '0;
    busy  = '0;
    ack_v = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      xfer[j] = (state_q[j] == LOCK) && req_by_out[j][owner_q[j]] && bus.ordy[j];
      busy    = busy | own_by_out[j];
      if (xfer[j]) begin
        ack_v = ack_v | own_by_out[j];
      end
    end
  end

  assign bus.ack  = ack_v;
  assign bus.ovld = xfer;
  assign bus.err  = err_q;

  // Outputs resolve in index order; an input won by a lower output this
  // cycle is masked from the higher ones so no input gets two grants.
  always_comb begin : arb
    logic       found;
    logic [1:0] win;
    logic [1:0] cand;
    picked = '0;
    err_d  = err_q;
    found  = 1'b0;
    win    = '0;
    cand   = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
      if (state_q[j] == IDLE) begin
        cnt_d[j] = '0;
        found    = 1'b0;
        win      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
          cand = ptr_q[j] + 2'(k);
          if (!found && req_by_out[j][cand] && !busy[cand] && !picked[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          state_d[j]  = LOCK;
          owner_d[j]  = win;
          picked[win] = 1'b1;
        end
      end else begin
        if (xfer[j]) begin
          // A transfer always wins over a timeout in the same cycle.
          cnt_d[j] = '0;
          if (bus.tail[owner_q[j]]) begin
            state_d[j] = IDLE;
            ptr_d[j]   = owner_q[j] + 2'd1;
          end
        end else if (cnt_q[j] == TMO_LAST) begin
          state_d[j] = IDLE;
          ptr_d[j]   = owner_q[j] + 2'd1;
          cnt_d[j]   = '0;
          err_d[j]   = 1'b1;
        end else begin
          cnt_d[j] = cnt_q[j] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned j = 0; j < 4; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
        cnt_q[j]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int unsigned j = 0; j < 4; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: doc/xbar_sched.md
XBAR_SCHED -- requirements
Module: xbar_sched

Interface
REQ-001 SHALL have parameter TMO, default 16, meaning stall cycles (no transfer while locked) before forced release; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  16  req[i*4+j]: input buffer i has a flit at its head destined for output j.
REQ-005 SHALL have port tail  input  4  tail[i]: head flit of input i is the last flit of its packet.
REQ-006 SHALL have port ordy  input  4  ordy[j]: output j can accept a flit this cycle.
REQ-007 SHALL have port grant  output  16  grant[j*4+i]: output j is locked to input i; drives crossbar select.
REQ-008 SHALL have port ack  output  4  ack[i]: head flit of input i is transferred this cycle (pop the buffer).
REQ-009 SHALL have port ovld  output  4  ovld[j]: a flit is transferred to output j this cycle.
REQ-010 SHALL have port err  output  4  err[j]: sticky; output j has had a timeout release.

Function
REQ-011 SHALL keep, per output j: state IDLE/LOCK, 2-bit owner, 2-bit round-robin pointer ptr[j], 8-bit stall counter.
REQ-012 SHALL make grant registered: grant[j*4+i]=1 iff output j in LOCK with owner i; at most one bit per output and per input.
REQ-013 SHALL compute xfer[j] = LOCK[j] & req[owner*4+j] & ordy[j] combinationally; ovld[j]=xfer[j]; ack[i]=OR over j of xfer[j] with owner i.
REQ-014 SHALL, for each IDLE output j, pick a winner among eligible inputs i with req[i*4+j]=1, searching ptr[j], ptr[j]+1, ... mod 4.
REQ-015 SHALL treat an input as ineligible if it is owner of any LOCK output, or was picked this cycle by a lower-numbered output (outputs resolved 0 to 3).
REQ-016 SHALL, on a winner, enter LOCK with owner=winner at the next edge; grant is visible one cycle after the request is first seen.
REQ-017 SHALL NOT transfer in the arbitration cycle; the first flit moves no earlier than the cycle grant is high.
REQ-018 SHALL hold LOCK across cycles with ordy low or req low (packet-granular lock; no interleaving).
REQ-019 SHALL, on xfer[j] & tail[owner], return to IDLE at the next edge and set ptr[j]=owner+1 mod 4.
REQ-020 SHALL incur one idle cycle on output j between a tail transfer and the next grant (re-arbitration cycle).
REQ-021 SHALL accept a single-flit packet (tail high on the first flit): one transfer, then release.
REQ-022 SHALL clear the stall counter on entering LOCK, on every xfer, and while IDLE; otherwise increment it each LOCK cycle.
REQ-023 SHALL, when the counter equals TMO-1 in a cycle with no xfer, force IDLE at the next edge, set ptr[j]=owner+1 mod 4, and set err[j]=1.
REQ-024 SHALL give xfer priority over timeout in the same cycle (transfer, counter clears, no err).
REQ-025 SHALL leave ptr[j] unchanged on cycles with no release.
REQ-026 SHALL clear err only by reset.

Reset
REQ-027 SHALL, when rst=0 at an edge, set all outputs to IDLE, owner=0, ptr=0, counters=0, err=0; grant=0, hence ack=0 and ovld=0 the next cycle.
REQ-028 SHALL abandon any in-progress packet on reset with no further ack for it; arbitration resumes the first cycle rst=1.

Verification
REQ-029 SHALL be verified by a single request: req[1*4+2]=1, ordy=4'hF, tail[1]=1 at cycle 0 -> grant[2*4+1]=1 at cycle 1, ack[1]=ovld[2]=1 at cycle 1, grant=0 at cycle 2, ptr[2]=2.
REQ-030 SHALL be verified by contention: inputs 0 and 3 request output 0 continuously with 2-flit packets -> grants alternate 0,3,0,3, each lock 2 transfer cycles plus 1 idle cycle.
REQ-031 SHALL be verified by input masking: input 1 requests outputs 0 and 1 in the same cycle, all IDLE -> only grant[0*4+1]=1; output 1 not granted to input 1 while it is locked to output 0.
REQ-032 SHALL be verified by backpressure: locked 3-flit packet with ordy[j] low for 5 cycles mid-packet, TMO=16 -> grant held, no ack during the stall, err[j]=0.
REQ-033 SHALL be verified by timeout: TMO=4, owner's req dropped after the first flit -> forced release after 4 stalled LOCK cycles, err[j]=1 and sticky, ptr advanced.
REQ-034 SHALL be verified by reset mid-packet: rst=0 for one cycle during LOCK -> grant=0, ack=0, err=0, ptr=0 the cycle after; arbitration restarts when rst=1.
